// File: rtl/spike_rate_encoder_pkg.sv
// Shared sizing defaults and FSM state type for the spike rate encoder and its neighbours
// (input_neuron array, image loader).
package spike_rate_encoder_pkg;

    localparam int unsigned NPix   = 16;
    localparam int unsigned PixW   = 8;
    localparam int unsigned TSteps = 20;
    localparam int unsigned TsW    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFire,
        StWait,
        StFinish
    } state_e;

endpackage

// File: rtl/spike_rate_encoder_rate_accum_lane.sv
// One lane of the rate coder: a wrapping PIX_W accumulator whose carry-out is the spike.
module rate_accum_lane
    import spike_rate_encoder_pkg::*;
#(
    parameter int unsigned PIX_W = PixW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             fire_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic             spike_o
);

    logic [PIX_W-1:0] acc_q, acc_d;
    logic             spike_q, spike_d;
    logic [PIX_W:0]   sum;

    // The spike holds between fires; only the accumulator is cleared per image.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, pix_i};
        acc_d   = acc_q;
        spike_d = spike_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (fire_i) begin
            acc_d   = sum[PIX_W-1:0];
            spike_d = sum[PIX_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Buffers one image and presents it as T_STEPS rate-coded spike vectors, pacing each
// timestep on the collected done pulses of all neuron lanes.
module spike_rate_encoder
    import spike_rate_encoder_pkg::*;
#(
    parameter int unsigned N_PIX   = NPix,
    parameter int unsigned PIX_W   = PixW,
    parameter int unsigned T_STEPS = TSteps,
    parameter int unsigned TS_W    = TsW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pix_valid_i,
    input  logic [PIX_W-1:0] pix_data_i,
    output logic             pix_ready_o,
    output logic [N_PIX-1:0] spike_out_o,
    output logic             start_o,
    output logic             start_core_img_o,
    input  logic [N_PIX-1:0] neuron_done_i,
    output logic [TS_W-1:0]  step_o,
    output logic             busy_o,
    output logic             img_done_o
);

    localparam int unsigned IdxW = (N_PIX > 1) ? $clog2(N_PIX) : 1;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [TS_W-1:0]  step_q, step_d;
    logic [N_PIX-1:0] seen_q, seen_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [PIX_W-1:0] pix_q [N_PIX];
    logic             accept, lane_clear, lane_fire;

    assign pix_ready_o = (state_q == StIdle);
    assign accept      = pix_valid_i & pix_ready_o;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        step_d     = step_q;
        seen_d     = seen_q;
        busy_d     = busy_q;
        start_d    = 1'b0;
        lane_clear = 1'b0;
        lane_fire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d  = idx_q + 1'b1;
                    busy_d = 1'b1;
                    if (idx_q == IdxW'(N_PIX - 1)) state_d = StClear;
                end
            end
            StClear: begin
                lane_clear = 1'b1;
                step_d     = '0;
                state_d    = StFire;
            end
            StFire: begin
                lane_fire = 1'b1;
                start_d   = 1'b1;
                seen_d    = '0;
                state_d   = StWait;
            end
            StWait: begin
                // Pulses landing this cycle count toward completion of the step.
                seen_d = seen_q | neuron_done_i;
                if (&seen_d) begin
                    if (step_q == TS_W'(T_STEPS - 1)) begin
                        busy_d  = 1'b0;
                        state_d = StFinish;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = StFire;
                    end
                end
            end
            StFinish: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            step_q  <= '0;
            seen_q  <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N_PIX); i++) pix_q[i] <= '0;
        end else if (accept) begin
            pix_q[idx_q] <= pix_data_i;
        end
    end

    for (genvar g = 0; g < int'(N_PIX); g++) begin : g_lane
        rate_accum_lane #(
            .PIX_W(PIX_W)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (lane_clear),
            .fire_i  (lane_fire),
            .pix_i   (pix_q[g]),
            .spike_o (spike_out_o[g])
        );
    end

    assign start_o          = start_q;
    assign start_core_img_o = (state_q == StClear);
    assign img_done_o       = (state_q == StFinish);
    assign step_o           = step_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: per-lane spike patterns from a hand-computed vector
// table, plus stall, staggered-done, mid-image reset and back-to-back image sequences.
module tb_spike_rate_encoder;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready_o;
    logic [15:0] spike_out_o;
    logic        start_o;
    logic        start_core_img_o;
    logic [15:0] neuron_done;
    logic [7:0]  step_o;
    logic        busy_o;
    logic        img_done_o;

    always #5 clk = ~clk;

    spike_rate_encoder u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .pix_valid_i      (pix_valid),
        .pix_data_i       (pix_data),
        .pix_ready_o      (pix_ready_o),
        .spike_out_o      (spike_out_o),
        .start_o          (start_o),
        .start_core_img_o (start_core_img_o),
        .neuron_done_i    (neuron_done),
        .step_o           (step_o),
        .busy_o           (busy_o),
        .img_done_o       (img_done_o)
    );

    typedef struct {
        logic [7:0]  pix;
        logic [19:0] pat;
        int          cnt;
    } vec_t;

    vec_t        vt [16];
    logic [7:0]  img [16];
    int          n_chk = 0;
    int          n_pass = 0;

    // Monitor state
    int          cyc = 0;
    int          n_start, n_core, n_done, viol, gap_bad, last_start;
    logic        core_seen;
    logic [19:0] pat [16];
    int          scnt [16];

    // Neuron echo model state
    logic [15:0] pend = '0;
    logic [15:0] hold = '0;
    int          cnt [16];
    int          dly [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic clr_mon();
        n_start = 0; n_core = 0; n_done = 0; viol = 0; gap_bad = 0; last_start = -1;
        core_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pat[i] = '0;
            scnt[i] = 0;
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (start_o) begin
                n_start++;
                if (!core_seen) viol++;
                if (last_start >= 0 && cyc - last_start != 3) gap_bad++;
                last_start = cyc;
                for (int i = 0; i < 16; i++) begin
                    if (spike_out_o[i]) scnt[i]++;
                    if (step_o < 8'd20) pat[i][step_o[4:0]] = spike_out_o[i];
                end
            end
            if (start_core_img_o) begin
                n_core++;
                core_seen = 1'b1;
            end
            if (start_o && start_core_img_o) viol++;
            if (img_done_o) n_done++;
        end
    end

    // Each lane pulses done dly[i] cycles after it sees start, unless held.
    initial begin
        logic [15:0] nd;
        neuron_done = '0;
        forever begin
            @(posedge clk);
            #1;
            nd = '0;
            if (!rst_ni) begin
                pend = '0;
            end else begin
                for (int i = 0; i < 16; i++) begin
                    if (pend[i]) begin
                        if (cnt[i] != 0) cnt[i]--;
                        else if (!hold[i]) begin
                            nd[i] = 1'b1;
                            pend[i] = 1'b0;
                        end
                    end
                end
                if (start_o) begin
                    for (int i = 0; i < 16; i++) begin
                        pend[i] = 1'b1;
                        cnt[i] = dly[i] - 1;
                    end
                end
            end
            neuron_done = nd;
        end
    end

    task automatic load(input bit hold_valid);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) chk("ready_before_load", 32'(pix_ready_o), 32'd1);
            pix_valid = 1'b1;
            pix_data = img[i];
            @(posedge clk);
            #1;
            if (i == 0) chk("busy_after_first", 32'(busy_o), 32'd1);
        end
        chk("ready_low_after_last", 32'(pix_ready_o), 32'd0);
        pix_valid = hold_valid;
        pix_data = 8'h5A;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!img_done_o && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(nm, 32'(img_done_o), 32'd1);
    endtask

    task automatic finish_img(input bit mixed);
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("img_done_one_cycle", 32'(img_done_o), 32'd0);
        chk("n_start", 32'(n_start), 32'd20);
        chk("n_core", 32'(n_core), 32'd1);
        chk("n_done", 32'(n_done), 32'd1);
        chk("strobe_order", 32'(viol), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("lane%0d_pat", i), 32'(pat[i]), mixed ? 32'(vt[i].pat) : 32'hAAAAA);
            chk($sformatf("lane%0d_cnt", i), 32'(scnt[i]), mixed ? 32'(vt[i].cnt) : 32'd10);
        end
    endtask

    initial begin
        int k, s;
        vt[0]  = '{8'd0,   20'h00000, 0};
        vt[1]  = '{8'd64,  20'h88888, 5};
        vt[2]  = '{8'd255, 20'hFFFFE, 19};
        vt[3]  = '{8'd128, 20'hAAAAA, 10};
        vt[4]  = '{8'd192, 20'hEEEEE, 15};
        vt[5]  = '{8'd13,  20'h80000, 1};
        vt[6]  = '{8'd1,   20'h00000, 0};
        vt[7]  = '{8'd255, 20'hFFFFE, 19};
        vt[8]  = '{8'd64,  20'h88888, 5};
        vt[9]  = '{8'd0,   20'h00000, 0};
        vt[10] = '{8'd128, 20'hAAAAA, 10};
        vt[11] = '{8'd192, 20'hEEEEE, 15};
        vt[12] = '{8'd13,  20'h80000, 1};
        vt[13] = '{8'd255, 20'hFFFFE, 19};
        vt[14] = '{8'd1,   20'h00000, 0};
        vt[15] = '{8'd64,  20'h88888, 5};

        rst_ni = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        for (int i = 0; i < 16; i++) dly[i] = 1;
        clr_mon();
        #3;
        chk("rst_spike", 32'(spike_out_o), 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_core", 32'(start_core_img_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_step", 32'(step_o), 32'd0);
        chk("rst_done", 32'(img_done_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(pix_ready_o), 32'd1);

        // Image A: all 128, prompt done, minimum 3-cycle step period.
        for (int i = 0; i < 16; i++) img[i] = 8'd128;
        clr_mon();
        load(1'b0);
        wait_done("imgA_done");
        chk("imgA_busy_at_done", 32'(busy_o), 32'd0);
        chk("imgA_step_at_done", 32'(step_o), 32'd19);
        finish_img(1'b0);
        chk("imgA_step_period", 32'(gap_bad), 32'd0);

        // Image B: mixed pixels, staggered done, pix_valid held high throughout.
        for (int i = 0; i < 16; i++) begin
            img[i] = vt[i].pix;
            dly[i] = 1 + (i % 4);
        end
        clr_mon();
        load(1'b1);
        wait_done("imgB_done");
        finish_img(1'b1);

        // Image C: same pixels, lane 5 withholds done for 50 cycles at step 2.
        for (int i = 0; i < 16; i++) dly[i] = 1;
        clr_mon();
        load(1'b0);
        k = 0;
        s = 0;
        while (s < 3 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
            if (start_o) s++;
        end
        chk("imgC_third_start", 32'(s), 32'd3);
        hold[5] = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("stall_no_start", 32'(n_start), 32'd3);
        chk("stall_step", 32'(step_o), 32'd2);
        chk("stall_busy", 32'(busy_o), 32'd1);
        hold[5] = 1'b0;
        k = 0;
        while (!start_o && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("stall_resume", 32'(start_o), 32'd1);
        chk("stall_resume_step", 32'(step_o), 32'd3);
        wait_done("imgC_done");
        finish_img(1'b1);

        // Image D aborted by reset during step 7.
        for (int i = 0; i < 16; i++) img[i] = 8'd128;
        clr_mon();
        load(1'b0);
        k = 0;
        while (!(start_o && step_o == 8'd7) && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("imgD_reach_step7", 32'(step_o), 32'd7);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_spike", 32'(spike_out_o), 32'd0);
        chk("mid_rst_start", 32'(start_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_step", 32'(step_o), 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        clr_mon();
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 32'(pix_ready_o), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_start", 32'(n_start), 32'd0);
        chk("mid_rst_no_core", 32'(n_core), 32'd0);
        chk("mid_rst_no_done", 32'(n_done), 32'd0);

        // Image E: mixed pixels after reset must load from index 0.
        for (int i = 0; i < 16; i++) img[i] = vt[i].pix;
        clr_mon();
        load(1'b0);
        wait_done("imgE_done");
        finish_img(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
Transmitter side of the input-neuron interface. Buffers one image of N_PIX pixel intensities and converts each into a deterministic rate-coded spike train of T_STEPS timesteps. Drives per-lane spike lines with a common start strobe and a per-image counter-clear strobe (start_core_img), and paces timesteps on the neurons' done pulses. Sits between the image loader and the input_neuron array.

Parameters:
N_PIX, 16, number of pixels/input-neuron lanes
PIX_W, 8, pixel intensity width
T_STEPS, 20, timesteps presented per image (below the neuron window of 21)
TS_W, 8, width of timestep counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pix_valid  in  1  pixel word valid
pix_data  in  PIX_W  pixel intensity, lane order 0..N_PIX-1
pix_ready  out  1  encoder accepting pixels
spike_out  out  N_PIX  per-lane spike value, stable while start=1
start  out  1  one-cycle timestep strobe to all neurons
start_core_img  out  1  one-cycle per-image strobe, clears neuron counters
neuron_done  in  N_PIX  per-lane one-cycle done pulses from neurons
step  out  TS_W  current timestep index
busy  out  1  high from first accepted pixel until img_done
img_done  out  1  one-cycle pulse after last timestep completes

Behaviour:
- Reset (rst=0, async): state IDLE; spike_out=0, start=0, start_core_img=0, img_done=0, busy=0, step=0, pix_ready=1 (once rst deasserts), load index=0, all accumulators and pixel buffer=0, done_seen=0. Reset mid-image abandons it; no strobes emitted afterwards.
- IDLE/LOAD: pix_ready=1. Pixel accepted when pix_valid&&pix_ready, stored at load index, index++. busy rises on first accept. After pixel N_PIX-1 is accepted: pix_ready=0 next cycle, go CLEAR. pix_valid while pix_ready=0 is ignored.
- CLEAR (1 cycle): start_core_img=1; all accumulators cleared to 0; step=0. Next FIRE.
- FIRE (1 cycle): per lane, sum = acc + pix (PIX_W+1 bits); spike_out[i] <= sum[PIX_W]; acc <= sum[PIX_W-1:0]. start=1 in the same registered cycle as the new spike_out. done_seen cleared. Next WAIT.
- WAIT: done_seen |= neuron_done each cycle. When done_seen (including this cycle's pulses) is all ones: if step==T_STEPS-1 go FINISH, else step++ and go FIRE. No timeout; a missing lane stalls indefinitely (by design, visible via busy).
- spike_out holds its value from FIRE until next FIRE or reset; not cleared between steps.
- FINISH (1 cycle): img_done=1, busy=0, load index=0, step holds T_STEPS-1; next IDLE.
- Neuron_done pulses arriving outside WAIT are ignored.
- Spike count per lane over one image = floor(T_STEPS*pix/2^PIX_W); pix=0 never spikes.
- start and start_core_img are never high in the same cycle; start_core_img is at least one cycle before the first start.
- Step-to-step minimum period: 3 cycles (FIRE, WAIT with done arriving next cycle, transition).

Decomposition:
- Shared package: PIX_W, N_PIX, T_STEPS defaults (also used by input_neuron array and loader), state enum (IDLE, CLEAR, FIRE, WAIT, FINISH).
- One natural sub-module: rate_accum_lane (per-lane PIX_W accumulator + overflow spike), generated N_PIX times; top holds FSM, pixel buffer and done collection.

Test Plan:
- Load pixels all 128, neurons echo done 1 cycle after start -> every lane spikes at steps 1,3,...,19 (10 spikes), 20 start pulses, one start_core_img before first start, img_done once.
- Lane pixels 0/64/255 -> spike counts 0 / 5 (steps 3,7,11,15,19) / 19 (steps 1..19).
- Hold neuron_done of lane 5 off for 50 cycles, others prompt -> no new start until lane 5 pulses; then next FIRE.
- Lane done pulses staggered over 4 cycles -> done_seen accumulates, single advance per step.
- Assert rst low during WAIT at step 7 -> outputs to reset values immediately, pix_ready=1 after release, new image loads from index 0.
- pix_valid held high during presentation -> no extra pixels stored; second image after img_done produces identical spike pattern for identical pixels.
